jt49_lpfdec: RTL and testbench

//  Downstream stage of the JT49 DC-removal filter. Consumes its signed 8-bit output at the
//  PSG sample strobe and applies a programmable first-order IIR low-pass. It decimates by a
//  run-time ratio and hands samples to the audio mixer through a 2-entry valid/ready FIFO.
//  An overrun flag reports samples that were dropped because the mixer stalled.

---
 rtl/jt49_lpfdec.sv | 234 +++++++++++++++++++++++
 tb/tb_jt49_lpfdec.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/jt49_lpfdec.sv
// ---------------------------------------------------------------------------
// jt49_lpfdec
//
// Post-processing stage after the JT49 DC-removal filter. Each PSG sample
// strobe updates a first-order IIR low-pass accumulator with a programmable
// shift. The result is decimated by a run-time ratio. Decimated samples go to
// the audio mixer through a 2-entry valid/ready FIFO. A sticky overrun flag
// records samples that were dropped because the mixer stalled.
//
// Parameters
//   FRAC  fractional bits of the accumulator (AW = 8 + FRAC)
//   OW    output width (OW <= AW); the output is the top OW bits of acc
//   DECW  width of the decimation ratio port
//
// Ports
//   clk          system clock
//   rst_n        asynchronous reset, active low
//   cen          input sample strobe, one clk wide
//   din          signed 8-bit input sample, taken when cen=1
//   k            low-pass shift (0 = bypass)
//   ratio        decimation ratio R (0 behaves as 1)
//   dout         signed FIFO head sample, 0 when the FIFO is empty
//   dout_valid   FIFO not empty
//   dout_ready   consumer takes the head when dout_valid & dout_ready
//   overrun      sticky flag: a decimated sample was dropped
//   overrun_clr  clears overrun; a drop in the same cycle wins
//
// Build option
//   JT49_LPFDEC_ROUND_EN : when defined, the output sample is rounded by half
//   an output LSB and saturated. Otherwise the output is a plain truncation
//   toward -inf.
// ---------------------------------------------------------------------------
module jt49_lpfdec #(
  parameter int unsigned FRAC = 8,
  parameter int unsigned OW   = 12,
  parameter int unsigned DECW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cen,
  input  logic signed [7:0]    din,
  input  logic [3:0]           k,
  input  logic [DECW-1:0]      ratio,
  output logic signed [OW-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 overrun,
  input  logic                 overrun_clr
);

  localparam int unsigned AW = 8 + FRAC;
  localparam int unsigned SH = AW - OW;

  // -------------------------------------------------------------------------
  // IIR low-pass: acc += (din<<FRAC - acc) >>> k
  // -------------------------------------------------------------------------
  logic signed [AW-1:0] r_acc;
  logic signed [AW:0]   w_target;
  logic signed [AW:0]   w_diff;
  logic signed [AW:0]   w_step;
  logic signed [AW-1:0] w_acc_next;
  logic                 w_unused;

  assign w_target = {din[7], din, {FRAC{1'b0}}};
  assign w_diff   = w_target - {r_acc[AW-1], r_acc};
  assign w_step   = w_diff >>> k;
  // The shifted step never moves acc past the target, so the sum fits AW bits.
  assign w_acc_next = r_acc + w_step[AW-1:0];
  assign w_unused   = w_step[AW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (cen) begin
      r_acc <= w_acc_next;
    end
  end

  // -------------------------------------------------------------------------
  // Decimator
  // -------------------------------------------------------------------------
  logic [DECW-1:0] r_cnt;
  logic [DECW-1:0] w_last_idx;
  logic            w_push;

  assign w_last_idx = (ratio == '0) ? '0 : ratio - DECW'(1);
  // ">=" rather than "==": lowering the ratio below the current count makes
  // the next strobe push and wrap instead of running the counter around.
  assign w_push     = cen & (r_cnt >= w_last_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (cen) begin
      r_cnt <= w_push ? '0 : r_cnt + DECW'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Output sample formation
  // -------------------------------------------------------------------------
  logic signed [OW-1:0] w_sample;

`ifdef JT49_LPFDEC_ROUND_EN
  generate
    if (SH == 0) begin : g_full_width
      assign w_sample = w_acc_next;
    end else begin : g_round
      logic signed [AW:0] w_rnd_sum;
      logic signed [OW:0] w_rnd;
      logic               w_rnd_unused;

      assign w_rnd_sum    = {w_acc_next[AW-1], w_acc_next} + ((AW+1)'(1) << (SH-1));
      assign w_rnd        = w_rnd_sum[AW:SH];
      assign w_rnd_unused = ^w_rnd_sum[SH-1:0];

      // One guard bit above the output: a disagreement with the sign bit
      // means the rounded value left the OW-bit range.
      always_comb begin
        w_sample = w_rnd[OW-1:0];
        if (w_rnd[OW] != w_rnd[OW-1]) begin
          w_sample = w_rnd[OW] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
        end
      end
    end
  endgenerate
`else
  assign w_sample = w_acc_next[AW-1 -: OW];
`endif

  // -------------------------------------------------------------------------
  // 2-entry FIFO: occupancy state plus head/tail registers
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    FIFO_EMPTY,
    FIFO_ONE,
    FIFO_FULL
  } fifo_state_t;

  fifo_state_t          r_state;
  fifo_state_t          w_state_next;
  logic signed [OW-1:0] r_head;
  logic signed [OW-1:0] r_tail;
  logic                 w_pop;
  logic                 w_drop;
  logic                 w_head_ld_new;
  logic                 w_head_ld_tail;
  logic                 w_tail_ld;

  assign dout_valid = (r_state != FIFO_EMPTY);
  assign w_pop      = dout_valid & dout_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_drop     = w_push & (r_state == FIFO_FULL) & ~w_pop;
  assign dout       = dout_valid ? r_head : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FIFO_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_head_ld_new  = 1'b0;
    w_head_ld_tail = 1'b0;
    w_tail_ld      = 1'b0;
    case (r_state)
      FIFO_EMPTY: begin
        if (w_push) begin
          w_state_next  = FIFO_ONE;
          w_head_ld_new = 1'b1;
        end
      end
      FIFO_ONE: begin
        case ({w_push, w_pop})
          2'b11: w_head_ld_new = 1'b1;
          2'b01: w_state_next  = FIFO_EMPTY;
          2'b10: begin
            w_tail_ld    = 1'b1;
            w_state_next = FIFO_FULL;
          end
          default: ;
        endcase
      end
      FIFO_FULL: begin
        if (w_pop) begin
          w_head_ld_tail = 1'b1;
          if (w_push) begin
            w_tail_ld = 1'b1;
          end else begin
            w_state_next = FIFO_ONE;
          end
        end
      end
      default: w_state_next = FIFO_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_head_ld_new) begin
        r_head <= w_sample;
      end else if (w_head_ld_tail) begin
        r_head <= r_tail;
      end
      if (w_tail_ld) begin
        r_tail <= w_sample;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Sticky overrun flag
  // -------------------------------------------------------------------------
  logic r_overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (overrun_clr) begin
      r_overrun <= 1'b0;
    end
  end

  assign overrun = r_overrun;

endmodule

// File: tb/tb_jt49_lpfdec.sv
module tb_jt49_lpfdec;

  logic        clk         = 1'b0;
  logic        rst_n       = 1'b1;
  logic        cen         = 1'b0;
  logic [7:0]  din         = '0;
  logic [3:0]  k           = '0;
  logic [3:0]  ratio       = '0;
  logic        dout_ready  = 1'b0;
  logic        overrun_clr = 1'b0;
  logic [11:0] dout;
  logic        dout_valid;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jt49_lpfdec #(.FRAC(8), .OW(12), .DECW(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cen         (cen),
    .din         (din),
    .k           (k),
    .ratio       (ratio),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  // Reference model: integer accumulator, pulse counter, sample queue.
  int          m_acc = 0;
  int          m_cnt = 0;
  bit          m_ovr = 1'b0;
  logic [11:0] q[$];

  function automatic int floor_div(int a, int sh);
    int d;
    int r;
    d = 1 << sh;
    r = a / d;
    if ((a % d) != 0 && a < 0) r = r - 1;
    return r;
  endfunction

  function automatic logic [11:0] to_sample(int acc);
    int v;
`ifdef JT49_LPFDEC_ROUND_EN
    v = floor_div(acc + 8, 4);
    if (v > 2047) v = 2047;
    if (v < -2048) v = -2048;
`else
    v = floor_div(acc, 4);
`endif
    return v[11:0];
  endfunction

  task automatic chk(string tag, logic [11:0] got, logic [11:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock using the inputs currently applied, then compare.
  task automatic cyc();
    bit pop;
    bit push;
    bit drop;
    int nxt;
    int rr;
    int dv;
    pop  = (q.size() > 0) && dout_ready;
    push = 1'b0;
    nxt  = m_acc;
    if (cen) begin
      dv  = int'($signed(din));
      nxt = m_acc + floor_div(dv * 256 - m_acc, int'(k));
      rr  = (ratio == 0) ? 1 : int'(ratio);
      if (m_cnt >= rr - 1) begin
        push  = 1'b1;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
      m_acc = nxt;
    end
    drop = push && (q.size() == 2) && !pop;
    if (pop) void'(q.pop_front());
    if (push && !drop) q.push_back(to_sample(nxt));
    if (drop) m_ovr = 1'b1;
    else if (overrun_clr) m_ovr = 1'b0;
    @(posedge clk);
    #1;
    chk("valid", 12'(dout_valid), (q.size() > 0) ? 12'h1 : 12'h0);
    chk("dout", dout, (q.size() > 0) ? q[0] : 12'h0);
    chk("overrun", 12'(overrun), 12'(m_ovr));
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    cen   = 1'b0;
    #1;
    chk("rst_valid", 12'(dout_valid), 12'h0);
    chk("rst_dout", dout, 12'h0);
    chk("rst_overrun", 12'(overrun), 12'h0);
    m_acc = 0;
    m_cnt = 0;
    m_ovr = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // Bypass, single strobe
    k = 4'd0; ratio = 4'd1; din = 8'h40; dout_ready = 1'b1; cen = 1'b1;
    cyc();
    cen = 1'b0;
    chk("t1_valid", 12'(dout_valid), 12'h1);
    chk("t1_dout", dout, 12'h400);
    cyc();
    chk("t1_popped", 12'(dout_valid), 12'h0);

    // Zero the accumulator, then low-pass with k=2
    din = 8'h00; cen = 1'b1;
    cyc();
    cen = 1'b0;
    cyc();
    k = 4'd2; din = 8'h40; cen = 1'b1;
    cyc();
    chk("t2_first", dout, 12'h100);
    cyc();
    chk("t2_second", dout, 12'h1C0);
    cen = 1'b0;
    cyc();
    cyc();

    // Decimate by 4 over a ramp
    k = 4'd0; ratio = 4'd4; dout_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din = 8'(i); cen = 1'b1;
      cyc();
      if (i % 4 == 3) chk("t3_beat", dout, 12'(i * 16));
    end
    cen = 1'b0;
    cyc();

    // Stall: third sample dropped, then drain and clear
    ratio = 4'd1; dout_ready = 1'b0; cen = 1'b1;
    din = 8'd1; cyc();
    din = 8'd2; cyc();
    din = 8'd3; cyc();
    cen = 1'b0;
    chk("t4_overrun", 12'(overrun), 12'h1);
    chk("t4_head", dout, 12'h010);
    dout_ready = 1'b1;
    cyc();
    chk("t4_second", dout, 12'h020);
    cyc();
    chk("t4_empty", 12'(dout_valid), 12'h0);
    overrun_clr = 1'b1;
    cyc();
    overrun_clr = 1'b0;
    chk("t4_clr", 12'(overrun), 12'h0);

    // Full FIFO, push and pop together
    dout_ready = 1'b0; cen = 1'b1;
    din = 8'd4; cyc();
    din = 8'd5; cyc();
    din = 8'd6; dout_ready = 1'b1; cyc();
    cen = 1'b0; dout_ready = 1'b0;
    chk("t5_overrun", 12'(overrun), 12'h0);
    chk("t5_head", dout, 12'h050);
    dout_ready = 1'b1;
    cyc();
    chk("t5_next", dout, 12'h060);
    cyc();
    chk("t5_empty", 12'(dout_valid), 12'h0);

    // Reset mid-stream with a full FIFO and overrun set
    dout_ready = 1'b0; cen = 1'b1;
    din = 8'd7; cyc();
    din = 8'd8; cyc();
    din = 8'd9; cyc();
    cen = 1'b0;
    chk("t6_full", 12'(dout_valid), 12'h1);
    chk("t6_ovr", 12'(overrun), 12'h1);
    do_reset();

    // Positive full scale and an off-grid accumulator value
    k = 4'd0; ratio = 4'd1; dout_ready = 1'b1; din = 8'h7F; cen = 1'b1;
    cyc();
    chk("t7_full_scale", dout, 12'h7F0);
    din = 8'h00;
    cyc();
    k = 4'd1; din = 8'h7F;
    for (int i = 0; i < 5; i++) cyc();
`ifdef JT49_LPFDEC_ROUND_EN
    chk("t7_offgrid", dout, 12'h7B1);
`else
    chk("t7_offgrid", dout, 12'h7B0);
`endif
    cen = 1'b0;
    cyc();

    // Randomized operation against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) k = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) ratio = 4'($urandom_range(0, 15));
      cen         = 1'($urandom_range(0, 1));
      din         = 8'($urandom);
      dout_ready  = (n < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      overrun_clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
